walking_one_checker: RTL and testbench

WALKING_ONE_CHECKER -- requirements
Module: walking_one_checker

---
 rtl/walking_one_checker.sv | 174 +++++++++++++++++
 tb/tb_walking_one_checker.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/walking_one_checker.sv
`default_nettype none
// ============================================================================
//  Module   : walking_one_checker
//  Purpose  : Checks a looped-back walking-one pattern on NUM_PINS IO pins.
//             Synchronizes the pins, hunts for an in-sequence one-hot run,
//             then tracks the pattern and logs mismatches.
//  Revision : 1.0  initial release
// ============================================================================
module walking_one_checker #(
  parameter int NUM_PINS    = 20,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_COUNT  = 4,
  parameter int ERR_WIDTH   = 16,
  localparam int IDX_W      = (NUM_PINS > 1) ? $clog2(NUM_PINS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PINS-1:0]  io_in,
  input  logic                 sample_pulse,
  input  logic                 clear_err,
  output logic                 locked,
  output logic                 error,
  output logic [ERR_WIDTH-1:0] err_count,
  output logic [NUM_PINS-1:0]  fail_mask,
  output logic [IDX_W-1:0]     expected_idx,
  output logic                 nLED_RED,
  output logic                 nLED_GRN,
  output logic                 nLED_BLU
);

  localparam int GC_W = $clog2(LOCK_COUNT + 1);

  typedef enum logic [0:0] {
    HUNT  = 1'b0,
    TRACK = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [GC_W-1:0]       good_cnt_q, good_cnt_d;
  logic [IDX_W-1:0]      expected_idx_q, expected_idx_d;
  logic                  locked_q, locked_d;
  logic                  error_q, error_d;
  logic [ERR_WIDTH-1:0]  err_count_q, err_count_d;
  logic [NUM_PINS-1:0]   fail_mask_q, fail_mask_d;
  logic                  nled_red_q, nled_red_d;
  logic                  nled_grn_q, nled_grn_d;
  logic                  nled_blu_q, nled_blu_d;
  logic [NUM_PINS-1:0]   sync_q [SYNC_STAGES];
  logic [NUM_PINS-1:0]   sync_d [SYNC_STAGES];

  logic [NUM_PINS-1:0]   sample;
  logic                  sample_onehot;
  logic [IDX_W-1:0]      hit_idx;
  logic [NUM_PINS-1:0]   expected_vec;

  // Index of the pin after k, wrapping at the last pin.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] k);
    if (k == IDX_W'(NUM_PINS - 1)) next_idx = '0;
    else                           next_idx = k + IDX_W'(1);
  endfunction

  // Synchronizer shift chain; only the last stage is ever compared.
  always_comb begin
    sync_d[0] = io_in;
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
  end

  // Decode the synchronized sample: one-hot test, set-bit index, expected pattern.
  always_comb begin
    sample        = sync_q[SYNC_STAGES-1];
    sample_onehot = (sample != '0) && ((sample & (sample - NUM_PINS'(1))) == '0);
    hit_idx       = '0;
    for (int i = 0; i < NUM_PINS; i++) begin
      if (sample[i]) hit_idx = IDX_W'(i);
    end
    expected_vec  = {{(NUM_PINS-1){1'b0}}, 1'b1} << expected_idx_q;
  end

  // Next-state and next-output logic; nothing moves except on a strobe or clear.
  always_comb begin
    state_d        = state_q;
    good_cnt_d     = good_cnt_q;
    expected_idx_d = expected_idx_q;
    error_d        = error_q;
    err_count_d    = err_count_q;
    fail_mask_d    = fail_mask_q;

    if (clear_err) begin
      error_d     = 1'b0;
      err_count_d = '0;
      fail_mask_d = '0;
    end

    if (sample_pulse) begin
      case (state_q)
        HUNT: begin
          if (sample_onehot) begin
            if ((good_cnt_q != '0) && (hit_idx == expected_idx_q))
              good_cnt_d = good_cnt_q + GC_W'(1);
            else
              good_cnt_d = GC_W'(1);
            expected_idx_d = next_idx(hit_idx);
            if (good_cnt_d == GC_W'(LOCK_COUNT)) state_d = TRACK;
          end else begin
            // Junk samples restart the run but are not errors while hunting.
            good_cnt_d = '0;
          end
        end
        TRACK: begin
          if (sample == expected_vec) begin
            expected_idx_d = next_idx(expected_idx_q);
          end else begin
            // A mismatch overrides a coincident clear: it becomes the first
            // error of the new window, so the mask is recaptured too.
            error_d = 1'b1;
            if (clear_err)
              err_count_d = ERR_WIDTH'(1);
            else if (err_count_q != '1)
              err_count_d = err_count_q + ERR_WIDTH'(1);
            if (!error_q || clear_err) fail_mask_d = sample ^ expected_vec;
            state_d    = HUNT;
            good_cnt_d = '0;
          end
        end
        default: state_d = HUNT;
      endcase
    end

    locked_d   = (state_d == TRACK);
    nled_red_d = ~error_d;
    nled_grn_d = ~(locked_d & ~error_d);
    nled_blu_d = ~(~locked_d & ~error_d);
  end

  // State, status and synchronizer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= HUNT;
      good_cnt_q     <= '0;
      expected_idx_q <= '0;
      locked_q       <= 1'b0;
      error_q        <= 1'b0;
      err_count_q    <= '0;
      fail_mask_q    <= '0;
      nled_red_q     <= 1'b1;
      nled_grn_q     <= 1'b1;
      nled_blu_q     <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      state_q        <= state_d;
      good_cnt_q     <= good_cnt_d;
      expected_idx_q <= expected_idx_d;
      locked_q       <= locked_d;
      error_q        <= error_d;
      err_count_q    <= err_count_d;
      fail_mask_q    <= fail_mask_d;
      nled_red_q     <= nled_red_d;
      nled_grn_q     <= nled_grn_d;
      nled_blu_q     <= nled_blu_d;
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
    end
  end

  assign locked       = locked_q;
  assign error        = error_q;
  assign err_count    = err_count_q;
  assign fail_mask    = fail_mask_q;
  assign expected_idx = expected_idx_q;
  assign nLED_RED     = nled_red_q;
  assign nLED_GRN     = nled_grn_q;
  assign nLED_BLU     = nled_blu_q;

endmodule
`default_nettype wire

// File: tb/tb_walking_one_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_walking_one_checker
//  Purpose  : Directed self-checking bench for walking_one_checker, with a
//             second 2-bit error-counter instance for saturation.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_walking_one_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [19:0] io_in = '0;
  logic        sample_pulse = 1'b0;
  logic        clear_err = 1'b0;

  logic        locked, error, n_red, n_grn, n_blu;
  logic [15:0] err_count;
  logic [19:0] fail_mask;
  logic [4:0]  expected_idx;

  logic        locked2, error2, n_red2, n_grn2, n_blu2;
  logic [1:0]  err_count2;
  logic [19:0] fail_mask2;
  logic [4:0]  expected_idx2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  walking_one_checker dut (
    .clk(clk), .rst(rst), .io_in(io_in), .sample_pulse(sample_pulse),
    .clear_err(clear_err), .locked(locked), .error(error),
    .err_count(err_count), .fail_mask(fail_mask), .expected_idx(expected_idx),
    .nLED_RED(n_red), .nLED_GRN(n_grn), .nLED_BLU(n_blu)
  );

  walking_one_checker #(.ERR_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .io_in(io_in), .sample_pulse(sample_pulse),
    .clear_err(clear_err), .locked(locked2), .error(error2),
    .err_count(err_count2), .fail_mask(fail_mask2), .expected_idx(expected_idx2),
    .nLED_RED(n_red2), .nLED_GRN(n_grn2), .nLED_BLU(n_blu2)
  );

  // Present a pin pattern, let it settle through the synchronizer, then strobe once.
  task automatic drive(input logic [19:0] v, input logic clr = 1'b0);
    @(negedge clk) io_in = v;
    @(negedge clk);
    @(negedge clk);
    sample_pulse = 1'b1;
    clear_err    = clr;
    @(negedge clk);
    sample_pulse = 1'b0;
    clear_err    = 1'b0;
  endtask

  task automatic relock();
    for (int i = 0; i < 4; i++) drive(20'(1) << i);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %b exp 0", locked); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error got %b exp 0", error); end
    checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", err_count); end
    checks++; if (fail_mask !== 20'h0) begin errors++; $display("FAIL reset_mask got %h exp 0", fail_mask); end
    checks++; if (expected_idx !== 5'd0) begin errors++; $display("FAIL reset_idx got %0d exp 0", expected_idx); end
    checks++; if ({n_red, n_grn, n_blu} !== 3'b110) begin errors++; $display("FAIL reset_leds got %b exp 110", {n_red, n_grn, n_blu}); end
  endtask

  task automatic test_lock();
    for (int i = 0; i < 3; i++) drive(20'(1) << i);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lock_early got %b exp 0", locked); end
    checks++; if (expected_idx !== 5'd3) begin errors++; $display("FAIL lock_idx3 got %0d exp 3", expected_idx); end
    drive(20'h00008);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_locked got %b exp 1", locked); end
    checks++; if ({n_red, n_grn, n_blu} !== 3'b101) begin errors++; $display("FAIL lock_leds got %b exp 101", {n_red, n_grn, n_blu}); end
    checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL lock_cnt got %0d exp 0", err_count); end
    checks++; if (expected_idx !== 5'd4) begin errors++; $display("FAIL lock_idx got %0d exp 4", expected_idx); end
  endtask

  task automatic test_hold();
    @(negedge clk) io_in = 20'h00300;
    repeat (6) @(negedge clk);
    checks++; if (expected_idx !== 5'd4) begin errors++; $display("FAIL hold_idx got %0d exp 4", expected_idx); end
    checks++; if (locked !== 1'b1 || error !== 1'b0) begin errors++; $display("FAIL hold_state got %b%b exp 10", locked, error); end
  endtask

  task automatic test_wrap();
    logic [4:0] exp_seq [4];
    int         pins    [4];
    exp_seq = '{5'd19, 5'd0, 5'd1, 5'd2};
    pins    = '{18, 19, 0, 1};
    for (int i = 4; i < 18; i++) drive(20'(1) << i);
    checks++; if (expected_idx !== 5'd18 || locked !== 1'b1) begin errors++; $display("FAIL wrap_pre got idx %0d lk %b exp 18 1", expected_idx, locked); end
    for (int i = 0; i < 4; i++) begin
      drive(20'(1) << pins[i]);
      checks++;
      if (expected_idx !== exp_seq[i] || error !== 1'b0)
        begin errors++; $display("FAIL wrap_step%0d got idx %0d err %b exp %0d 0", i, expected_idx, error, exp_seq[i]); end
    end
    for (int i = 2; i < 20; i++) drive(20'(1) << i);
    checks++; if (expected_idx !== 5'd0 || locked !== 1'b1) begin errors++; $display("FAIL wrap_post got idx %0d lk %b exp 0 1", expected_idx, locked); end
  endtask

  task automatic test_fault();
    drive(20'h00003);
    checks++; if (error !== 1'b1 || err_count !== 16'd1) begin errors++; $display("FAIL fault1 got err %b cnt %0d exp 1 1", error, err_count); end
    checks++; if (fail_mask !== 20'h00002) begin errors++; $display("FAIL fault1_mask got %h exp 00002", fail_mask); end
    checks++; if ({locked, n_red, n_grn, n_blu} !== 4'b0011) begin errors++; $display("FAIL fault1_lk_leds got %b exp 0011", {locked, n_red, n_grn, n_blu}); end
    relock();
    checks++; if (locked !== 1'b1 || n_grn !== 1'b1) begin errors++; $display("FAIL relock_err got lk %b grn %b exp 1 1", locked, n_grn); end
    drive(20'h00000);
    checks++; if (fail_mask !== 20'h00002 || err_count !== 16'd2) begin errors++; $display("FAIL fault2 got mask %h cnt %0d exp 00002 2", fail_mask, err_count); end
    checks++; if (err_count2 !== 2'd2) begin errors++; $display("FAIL fault2_cnt2 got %0d exp 2", err_count2); end
  endtask

  task automatic test_clear();
    @(negedge clk) clear_err = 1'b1;
    @(negedge clk) clear_err = 1'b0;
    checks++; if (error !== 1'b0 || err_count !== 16'd0 || fail_mask !== 20'h0) begin errors++; $display("FAIL clear got err %b cnt %0d mask %h exp 0 0 0", error, err_count, fail_mask); end
    checks++; if (expected_idx !== 5'd4 || locked !== 1'b0 || n_blu !== 1'b0) begin errors++; $display("FAIL clear_keep got idx %0d lk %b blu %b exp 4 0 0", expected_idx, locked, n_blu); end
    relock();
    @(negedge clk) clear_err = 1'b1;
    @(negedge clk) clear_err = 1'b0;
    checks++; if (locked !== 1'b1 || expected_idx !== 5'd4 || n_grn !== 1'b0) begin errors++; $display("FAIL clear_locked got lk %b idx %0d grn %b exp 1 4 0", locked, expected_idx, n_grn); end
  endtask

  task automatic test_clear_coincident();
    drive(20'h00080);
    checks++; if (err_count !== 16'd1 || fail_mask !== 20'h00090) begin errors++; $display("FAIL coin_pre got cnt %0d mask %h exp 1 00090", err_count, fail_mask); end
    relock();
    drive(20'h00200, 1'b1);
    checks++; if (error !== 1'b1 || err_count !== 16'd1 || fail_mask !== 20'h00210) begin errors++; $display("FAIL coin got err %b cnt %0d mask %h exp 1 1 00210", error, err_count, fail_mask); end
    checks++; if (locked !== 1'b0 || err_count2 !== 2'd1) begin errors++; $display("FAIL coin_state got lk %b cnt2 %0d exp 0 1", locked, err_count2); end
  endtask

  task automatic test_saturate();
    @(negedge clk) clear_err = 1'b1;
    @(negedge clk) clear_err = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      relock();
      drive(20'h00000);
      if (n == 2) begin
        checks++; if (err_count2 !== 2'd2) begin errors++; $display("FAIL sat_mid got %0d exp 2", err_count2); end
      end
    end
    checks++; if (err_count2 !== 2'd3) begin errors++; $display("FAIL sat_hold got %0d exp 3", err_count2); end
    checks++; if (err_count !== 16'd5) begin errors++; $display("FAIL sat_wide got %0d exp 5", err_count); end
  endtask

  task automatic test_reset_mid_track();
    relock();
    @(negedge clk) io_in = 20'h00010;
    repeat (2) @(negedge clk);
    io_in = 20'h00001;
    rst = 1'b1; sample_pulse = 1'b1; clear_err = 1'b1;
    @(negedge clk);
    checks++; if ({locked, error, n_red, n_grn, n_blu} !== 5'b00110) begin errors++; $display("FAIL rst_mid got %b exp 00110", {locked, error, n_red, n_grn, n_blu}); end
    checks++; if (err_count !== 16'd0 || fail_mask !== 20'h0 || expected_idx !== 5'd0) begin errors++; $display("FAIL rst_mid_regs got cnt %0d mask %h idx %0d exp 0 0 0", err_count, fail_mask, expected_idx); end
    rst = 1'b0; clear_err = 1'b0;
    @(negedge clk);
    sample_pulse = 1'b0;
    checks++; if (expected_idx !== 5'd0) begin errors++; $display("FAIL rst_sync got idx %0d exp 0", expected_idx); end
    for (int i = 0; i < 3; i++) drive(20'(1) << i);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL rst_relock_early got %b exp 0", locked); end
    drive(20'h00008);
    checks++; if (locked !== 1'b1 || expected_idx !== 5'd4) begin errors++; $display("FAIL rst_relock got lk %b idx %0d exp 1 4", locked, expected_idx); end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_hold();
    test_wrap();
    test_fault();
    test_clear();
    test_clear_coincident();
    test_saturate();
    test_reset_mid_track();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
